sop_table_eval: RTL
===================

# sop_table_eval

Parametrised, programmable canonical-form boolean function unit. Holds an N-input function as a 2^N-bit truth table, interpreted as a minterm list (sum of products) or a maxterm list (product of sums). It evaluates the function on demand with a registered output. A sweep engine walks all 2^N input combinations, streams the truth table out, and reports the minterm count. It is the sequential, width-generic successor of the fixed 3-input SoP function blocks, and drives truth-table displays and self-checking benches.

## Interface
- N, default 3: number of function inputs; legal range 1..8.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  latch tbl_in and mode when high.
- mode  input  1  0 = SoP (tbl bit i = 1 marks minterm i), 1 = PoS (tbl bit i = 1 marks maxterm i).
- tbl_in  input  2^N  truth-table image; bit i corresponds to input vector i, with the MSB of the vector as the first variable (x).
- eval  input  1  request single evaluation of x.
- x  input  N  input vector for eval.
- s  output  1  registered f(x).
- s_valid  output  1  high one cycle when s is updated by eval.
- start  input  1  request full sweep.
- busy  output  1  sweep in progress.
- sweep_x  output  N  current swept input vector.
- sweep_s  output  1  f(sweep_x).
- sweep_valid  output  1  sweep_x/sweep_s valid this cycle.
- done  output  1  one-cycle pulse at end of sweep.
- count  output  N+1  number of vectors with f = 1 from the last completed sweep.

## Operation
- Function definition: f(i) = tbl[i] when mode_r = 0; f(i) = ~tbl[i] when mode_r = 1. tbl and mode_r are internal registers.
- Load behaviour:
  - load in IDLE: tbl <= tbl_in and mode_r <= mode at the clock edge.
  - load while busy: ignored. The table is frozen for the whole sweep.
  - load and start in the same IDLE cycle: load wins and start is ignored.
- Eval behaviour:
  - eval is accepted in any state, including during a sweep.
  - It uses the tbl and mode_r values present at that edge.
  - A load in the same cycle does not affect it; eval sees the old table.
  - s holds its value between evals.
- State machine:
  - IDLE: start (without load) -> SWEEP with idx = 0 and acc = 0.
  - SWEEP: each cycle sweep_valid = 1, sweep_x = idx, sweep_s = f(idx), acc += f(idx).
    - If idx == 2^N-1 -> DONE.
    - Otherwise idx += 1.
  - DONE: done = 1 and count <= final acc, including the last vector; then -> IDLE.
- busy = 1 in SWEEP and DONE. A start while busy is ignored.
- count is N+1 bits, so an all-ones function reports exactly 2^N with no wrap. count holds until the next sweep's DONE.
- idx is N bits and never wraps within a sweep; termination is by comparison with 2^N-1.
- Reset at any point, including mid-sweep:
  - Registers: state = IDLE, tbl = 0, mode_r = 0, idx = 0, acc = 0, count = 0.
  - Outputs: s = 0, s_valid = 0, busy = 0, sweep_x = 0, sweep_s = 0, sweep_valid = 0, done = 0.
  - A partial sweep produces no done.
  - Reset overrides load, start and eval in the same cycle.

## Timing
- load: the new table is visible to an eval or start issued in the next cycle.
- eval: s and s_valid appear 1 cycle after the eval edge. Back-to-back evals give one result per cycle.
- Sweep, with start sampled at edge T:
  - busy rises at T+1.
  - sweep_valid is high for cycles T+1 .. T+2^N.
  - done and the updated count appear at T+2^N+1.
  - busy falls at T+2^N+2, when a new start is accepted.
  - A start at T+2^N+1 (during DONE) is ignored.
- Sweep outputs are registered; sweep_x and sweep_s are 0 whenever sweep_valid = 0.

## Test plan
- SoP sweep: N=3, load tbl_in=8'b11001100, mode=0 (minterms 2,3,6,7), then start.
  -> sweep_s sequence 0,0,1,1,0,0,1,1 for sweep_x 0..7; done at start+9 cycles; count=4.
- PoS sweep: same table with mode=1.
  -> sweep_s 1,1,0,0,1,1,0,0; count=4.
  - Then load tbl_in=8'hFF, mode=0, sweep -> count=8 (no wrap).
- Eval: table 8'b11001100, mode 0; eval with x=3'b110, then x=3'b001 on the next cycle.
  -> s=1 with s_valid one cycle later, then s=0; s holds 0 after eval drops.
- Ignored requests:
  - Load 8'h00 at sweep cycle 3 -> remaining sweep_s values unchanged and count=4.
  - Start while busy -> no restart.
  - Load+start in the same IDLE cycle -> table loaded, busy stays 0.
- Reset mid-sweep: assert reset at sweep_x=5.
  -> next cycle all outputs are 0, done never pulses, and eval of any x gives s=0 (table cleared).
- Parameter check at N=1 and N=8 with an alternating table (0101...).
  -> count=2^(N-1); done at start+2^N+1 cycles.

Source files
------------

// File: rtl/sop_table_eval.sv
// Programmable N-input boolean function held as a 2^N-bit minterm/maxterm table,
// with registered single-shot evaluation and a full truth-table sweep engine.
module sop_table_eval #(
  parameter int unsigned N = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               mode,
  input  logic [(1<<N)-1:0]  tbl_in,
  input  logic               eval,
  input  logic [N-1:0]       x,
  output logic               s,
  output logic               s_valid,
  input  logic               start,
  output logic               busy,
  output logic [N-1:0]       sweep_x,
  output logic               sweep_s,
  output logic               sweep_valid,
  output logic               done,
  output logic [N:0]         count
);

  localparam int unsigned SIZE = 1 << N;
  localparam logic [N-1:0] LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_tbl;
  logic            r_mode;
  logic [N-1:0]    r_idx;
  logic [N:0]      r_acc;
  logic [N:0]      r_count;
  logic            r_s;
  logic            r_s_valid;
  logic            r_busy;
  logic [N-1:0]    r_sweep_x;
  logic            r_sweep_s;
  logic            r_sweep_valid;
  logic            r_done;

  logic [N-1:0]    w_idx_next;
  logic            w_f_x;
  logic            w_f_idx;
  logic            w_f_next;
  logic            w_f_first;
  logic [N:0]      w_acc_next;

  // f(i) is the table bit, inverted in PoS mode where set bits mark maxterms.
  assign w_idx_next = r_idx + 1'b1;
  assign w_f_x      = r_tbl[x] ^ r_mode;
  assign w_f_idx    = r_tbl[r_idx] ^ r_mode;
  assign w_f_next   = r_tbl[w_idx_next] ^ r_mode;
  assign w_f_first  = r_tbl[0] ^ r_mode;
  assign w_acc_next = r_acc + {{N{1'b0}}, w_f_idx};

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values; the eval path therefore reads the old table even
  // when a load lands on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is an ordinary register file here and is cleared on
      // reset, so a post-reset eval is defined as 0 rather than stale data.
      r_state       <= ST_IDLE;
      r_tbl         <= '0;
      r_mode        <= 1'b0;
      r_idx         <= '0;
      r_acc         <= '0;
      r_count       <= '0;
      r_s           <= 1'b0;
      r_s_valid     <= 1'b0;
      r_busy        <= 1'b0;
      r_sweep_x     <= '0;
      r_sweep_s     <= 1'b0;
      r_sweep_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_s_valid <= eval;
      if (eval) r_s <= w_f_x;
      r_done <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_tbl  <= tbl_in;
            r_mode <= mode;
          end else if (start) begin
            // Present vector 0 in the very next cycle so sweep_valid tracks busy.
            r_state       <= ST_SWEEP;
            r_busy        <= 1'b1;
            r_idx         <= '0;
            r_acc         <= '0;
            r_sweep_valid <= 1'b1;
            r_sweep_x     <= '0;
            r_sweep_s     <= w_f_first;
          end
        end
        ST_SWEEP: begin
          r_acc <= w_acc_next;
          if (r_idx == LAST) begin
            r_state       <= ST_DONE;
            r_sweep_valid <= 1'b0;
            r_sweep_x     <= '0;
            r_sweep_s     <= 1'b0;
            r_done        <= 1'b1;
            r_count       <= w_acc_next;
          end else begin
            r_idx     <= w_idx_next;
            r_sweep_x <= w_idx_next;
            r_sweep_s <= w_f_next;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s           = r_s;
  assign s_valid     = r_s_valid;
  assign busy        = r_busy;
  assign sweep_x     = r_sweep_x;
  assign sweep_s     = r_sweep_s;
  assign sweep_valid = r_sweep_valid;
  assign done        = r_done;
  assign count       = r_count;

endmodule
